// File: rtl/mul_arbiter.sv
// Round-robin arbiter that time-shares one sequential 4x4 multiplier among N requesters.
// A grant latches the winner's operands, pulses MUL_START, waits MUL_LAT cycles and then returns the product.
module mul_arbiter #(
    parameter int N       = 2,
    parameter int MUL_LAT = 6
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [N-1:0]         REQ,
    input  logic [4*N-1:0]       MD_IN,
    input  logic [4*N-1:0]       MQ_IN,
    output logic [N-1:0]         ACK,
    output logic [7:0]           ANS_OUT,
    output logic [$clog2(N)-1:0] GNT_ID,
    output logic                 BUSY,
    output logic [3:0]           MUL_MD,
    output logic [3:0]           MUL_MQ,
    output logic                 MUL_START,
    input  logic [7:0]           MUL_ANS,
    output logic [1:0]           dbg_state
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      md_n, mq_n;
    logic            start_n;
    logic [N-1:0]    ack_n;
    logic [7:0]      ans_n;
    logic [IW-1:0]   gnt_n;

    logic [N-1:0]    req_rot;
    logic [IW-1:0]   offset, win, ptr_inc;
    logic [IW:0]     win_sum, inc_sum;
    logic [3:0]      md_sel, mq_sel;
    logic [N-1:0]    ack_onehot;

    assign dbg_state = state;

    // Handshake: a requester holds REQ high until it sees its one-cycle ACK
    // pulse; ANS_OUT is valid in that cycle and REQ must drop before the
    // arbiter is back in IDLE, otherwise it counts as a fresh request.
    always_comb begin
        req_rot = N'({REQ, REQ} >> ptr);
        offset  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) offset = IW'(j);
        end
        win_sum = {1'b0, ptr} + {1'b0, offset};
        if (win_sum >= (IW+1)'(N)) win_sum = win_sum - (IW+1)'(N);
        win     = win_sum[IW-1:0];
        inc_sum = {1'b0, win} + (IW+1)'(1);
        if (inc_sum == (IW+1)'(N)) inc_sum = '0;
        ptr_inc = inc_sum[IW-1:0];

        md_sel     = '0;
        mq_sel     = '0;
        ack_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IW'(i)) begin
                md_sel = MD_IN[4*i +: 4];
                mq_sel = MQ_IN[4*i +: 4];
            end
            if (GNT_ID == IW'(i)) ack_onehot[i] = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        md_n    = MUL_MD;
        mq_n    = MUL_MQ;
        start_n = 1'b0;
        ack_n   = '0;
        ans_n   = ANS_OUT;
        gnt_n   = GNT_ID;
        case (state)
            IDLE: begin
                if (|REQ) begin
                    md_n    = md_sel;
                    mq_n    = mq_sel;
                    gnt_n   = win;
                    ptr_n   = ptr_inc;
                    start_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    ans_n   = MUL_ANS;
                    ack_n   = ack_onehot;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            MUL_MD    <= '0;
            MUL_MQ    <= '0;
            MUL_START <= 1'b0;
            ACK       <= '0;
            ANS_OUT   <= '0;
            GNT_ID    <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            MUL_MD    <= md_n;
            MUL_MQ    <= mq_n;
            MUL_START <= start_n;
            ACK       <= ack_n;
            ANS_OUT   <= ans_n;
            GNT_ID    <= gnt_n;
            BUSY      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural MUL of fixed latency.
// Expected grants, acknowledges and products are hand-computed per test.
module tb_mul_arbiter;

    localparam int N       = 2;
    localparam int MUL_LAT = 6;

    logic           CLOCK = 1'b0;
    logic           RESET;
    logic [N-1:0]   REQ;
    logic [4*N-1:0] MD_IN;
    logic [4*N-1:0] MQ_IN;
    logic [N-1:0]   ACK;
    logic [7:0]     ANS_OUT;
    logic [0:0]     GNT_ID;
    logic           BUSY;
    logic [3:0]     MUL_MD;
    logic [3:0]     MUL_MQ;
    logic           MUL_START;
    logic [7:0]     MUL_ANS;
    logic [1:0]     dbg_state;

    mul_arbiter #(.N(N), .MUL_LAT(MUL_LAT)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .REQ       (REQ),
        .MD_IN     (MD_IN),
        .MQ_IN     (MQ_IN),
        .ACK       (ACK),
        .ANS_OUT   (ANS_OUT),
        .GNT_ID    (GNT_ID),
        .BUSY      (BUSY),
        .MUL_MD    (MUL_MD),
        .MUL_MQ    (MUL_MQ),
        .MUL_START (MUL_START),
        .MUL_ANS   (MUL_ANS),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 CLOCK = ~CLOCK;

    // behavioural multiplier: samples START, product stable for the capture edge
    // MUL_LAT edges later, filler value while computing
    logic [3:0] m_a = '0;
    logic [3:0] m_b = '0;
    int         m_cnt = 0;
    logic [7:0] m_ans = 8'h00;
    logic       prev_start = 1'b0;
    int         dbl_start = 0;

    assign MUL_ANS = m_ans;

    always @(posedge CLOCK) begin
        prev_start <= MUL_START;
        if (MUL_START && prev_start) dbl_start <= dbl_start + 1;
        if (MUL_START) begin
            m_a   <= MUL_MD;
            m_b   <= MUL_MQ;
            m_cnt <= 1;
            m_ans <= 8'hA5;
        end else if (m_cnt != 0) begin
            if (m_cnt == MUL_LAT - 1) begin
                m_ans <= {4'b0, m_a} * {4'b0, m_b};
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // scoreboard
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wait_grant(input int exp_id);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!MUL_START && t < 40);
        check("grant_seen", 32'(MUL_START), 32'd1);
        check("gnt_id", 32'(GNT_ID), 32'(exp_id));
        check("busy_at_grant", 32'(BUSY), 32'd1);
    endtask

    // called right after the grant edge; drop is released at the second WAIT edge
    task automatic finish_op(input logic [N-1:0] exp_ack, input logic [N-1:0] drop);
        logic [7:0] exp_ans;
        logic       early;
        exp_ans = exp_q.pop_front();
        early   = 1'b0;
        tick();
        check("start_one_cycle", 32'(MUL_START), 32'd0);
        for (int k = 2; k <= MUL_LAT; k++) begin
            tick();
            if (ACK != '0) early = 1'b1;
            if (k == 2) REQ = REQ & ~drop;
        end
        check("ack_early", 32'(early), 32'd0);
        tick();
        check("ack", 32'(ACK), 32'(exp_ack));
        check("ans", 32'(ANS_OUT), 32'(exp_ans));
        REQ = REQ & ~ACK;
        tick();
        check("ack_one_cycle", 32'(ACK), 32'd0);
        check("idle_after_done", 32'(BUSY), 32'd0);
        check("ans_hold", 32'(ANS_OUT), 32'(exp_ans));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ACK), 32'd0);
        check({tag, "_ans"}, 32'(ANS_OUT), 32'd0);
        check({tag, "_gnt"}, 32'(GNT_ID), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_start"}, 32'(MUL_START), 32'd0);
        check({tag, "_md"}, 32'(MUL_MD), 32'd0);
        check({tag, "_mq"}, 32'(MUL_MQ), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        logic quiet;

        // reset held two cycles with both requests up
        RESET = 1'b1;
        REQ   = 2'b11;
        MD_IN = '0;
        MQ_IN = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        RESET = 1'b0;
        REQ   = 2'b00;

        // single request: 9 x 11 = 0x63
        REQ   = 2'b01;
        MD_IN = 8'h09;
        MQ_IN = 8'h0B;
        exp_q.push_back(8'h63);
        wait_grant(0);
        check("md_latched", 32'(MUL_MD), 32'h9);
        check("mq_latched", 32'(MUL_MQ), 32'hB);
        finish_op(2'b01, 2'b00);

        // simultaneous requests after reset: 6x3 = 0x12, 9x11 = 0x63, alternating
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        MD_IN = 8'h96;
        MQ_IN = 8'hB3;
        for (int r = 0; r < 4; r++) begin
            REQ = 2'b11;
            exp_q.push_back((r % 2 == 0) ? 8'h12 : 8'h63);
            wait_grant(r % 2);
            finish_op((r % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
        end
        REQ = 2'b00;

        // operand stability: operands change right after the grant
        REQ   = 2'b01;
        MD_IN = 8'h09;
        MQ_IN = 8'h0B;
        exp_q.push_back(8'h63);
        wait_grant(0);
        MD_IN = 8'h0F;
        finish_op(2'b01, 2'b00);
        check("md_kept", 32'(MUL_MD), 32'h9);

        // request withdrawn during WAIT: 5 x 7 = 0x23, still acknowledged, no regrant
        REQ   = 2'b10;
        MD_IN = 8'h50;
        MQ_IN = 8'h70;
        exp_q.push_back(8'h23);
        wait_grant(1);
        finish_op(2'b10, 2'b10);
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (MUL_START || BUSY) quiet = 1'b0;
        end
        check("no_regrant", 32'(quiet), 32'd1);

        // reset mid-operation: req0 granted (pointer moves to 1), reset in WAIT
        REQ   = 2'b01;
        MD_IN = 8'h0C;
        MQ_IN = 8'h0D;
        wait_grant(0);
        tick();
        tick();
        tick();
        RESET = 1'b1;
        REQ   = 2'b00;
        tick();
        RESET = 1'b0;
        check_reset_outputs("mid_reset");
        quiet = 1'b1;
        for (int k = 0; k < MUL_LAT + 3; k++) begin
            tick();
            if (ACK != '0 || BUSY) quiet = 1'b0;
        end
        check("no_ack_after_reset", 32'(quiet), 32'd1);
        REQ   = 2'b11;
        MD_IN = 8'h96;
        MQ_IN = 8'hB3;
        exp_q.push_back(8'h12);
        wait_grant(0);
        finish_op(2'b01, 2'b00);
        REQ = 2'b00;
        tick();

        check("start_never_twice", 32'(dbl_start), 32'd0);

        // report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
